// File: rtl/cmd_reg_sequencer_if.sv
// Bus bundle between the command sequencer and its command FIFO, register
// port and reply FIFO. The sequencer side uses the master modport.
interface cmd_reg_sequencer_if;
    logic        cmd_empty;
    logic [31:0] cmd_data;
    logic        cmd_rdreq;
    logic [1:0]  reg_enable;
    logic [6:0]  reg_addr;
    logic [31:0] reg_datain;
    logic [31:0] reg_dataout;
    logic        reply_full;
    logic        reply_wrreq;
    logic [31:0] reply_data;

    modport master (
        input  cmd_empty, cmd_data, reg_dataout, reply_full,
        output cmd_rdreq, reg_enable, reg_addr, reg_datain, reply_wrreq, reply_data
    );

    modport slave (
        output cmd_empty, cmd_data, reg_dataout, reply_full,
        input  cmd_rdreq, reg_enable, reg_addr, reg_datain, reply_wrreq, reply_data
    );
endinterface

// File: rtl/cmd_reg_sequencer.sv
// Register command sequencer: pops read/write commands from the command FIFO,
// drives one register access per command and returns a two-word reply for
// reads. Unknown opcodes are dropped and counted (saturating at 255).
module cmd_reg_sequencer #(
    parameter logic [7:0] OP_WRITE = 8'h05,
    parameter logic [7:0] OP_READ  = 8'h06,
    parameter logic [7:0] OP_REPLY = 8'h07
) (
    input  logic                  clk,
    input  logic                  reset,
    cmd_reg_sequencer_if.master   bus,
    output logic                  busy,
    output logic [7:0]            err_count
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        WRITE,
        READ,
        REPLY_HDR,
        REPLY_VAL
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  rid;
    logic [6:0]  addr;
    logic [31:0] datain;
    logic [31:0] value;
    logic [7:0]  opcode;

    assign opcode         = bus.cmd_data[31:24];
    assign bus.reg_addr   = addr;
    assign bus.reg_datain = datain;

    // State register; reset abandons any partial command at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Hold registers: request id/address, write data, readback value, error count.
    always_ff @(posedge clk) begin
        if (reset) begin
            rid       <= '0;
            addr      <= '0;
            datain    <= '0;
            value     <= '0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.cmd_empty) begin
                        if (opcode == OP_WRITE || opcode == OP_READ) begin
                            rid  <= bus.cmd_data[23:16];
                            addr <= bus.cmd_data[6:0];
                        end else if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (!bus.cmd_empty) begin
                        datain <= bus.cmd_data;
                    end
                end
                READ: begin
                    value <= bus.reg_dataout;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and strobe decode; everything is held low while reset is asserted.
    always_comb begin
        state_next      = state;
        bus.cmd_rdreq   = 1'b0;
        bus.reg_enable  = 2'b00;
        bus.reply_wrreq = 1'b0;
        bus.reply_data  = 32'h0;
        busy            = 1'b0;
        if (!reset) begin
            busy = (state != IDLE);
            case (state)
                IDLE: begin
                    if (!bus.cmd_empty) begin
                        bus.cmd_rdreq = 1'b1;
                        if (opcode == OP_WRITE) begin
                            state_next = WAIT_DATA;
                        end else if (opcode == OP_READ) begin
                            state_next = READ;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (!bus.cmd_empty) begin
                        bus.cmd_rdreq = 1'b1;
                        state_next    = WRITE;
                    end
                end
                WRITE: begin
                    bus.reg_enable = 2'b10;
                    state_next     = IDLE;
                end
                READ: begin
                    bus.reg_enable = 2'b11;
                    state_next     = REPLY_HDR;
                end
                REPLY_HDR: begin
                    if (!bus.reply_full) begin
                        bus.reply_wrreq = 1'b1;
                        bus.reply_data  = {OP_REPLY, rid, 9'b0, addr};
                        state_next      = REPLY_VAL;
                    end
                end
                REPLY_VAL: begin
                    if (!bus.reply_full) begin
                        bus.reply_wrreq = 1'b1;
                        bus.reply_data  = value;
                        state_next      = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule
